// File: rtl/sprite_rom_arbiter_if.sv
// Request/return bus between the two sprite renderers, the shared sprite ROM
// and sprite_rom_arbiter. The master side is the surrounding environment
// (renderers plus ROM); the slave side is the arbiter.
interface sprite_rom_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 4
);
   logic              enable;
   logic              req_p1;
   logic              req_p2;
   logic [ADDR_W-1:0] addr_p1;
   logic [ADDR_W-1:0] addr_p2;
   logic              gnt_p1;
   logic              gnt_p2;
   logic              rvalid_p1;
   logic              rvalid_p2;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] rom_address;
   logic [DATA_W-1:0] rom_q;
   logic [7:0]        conflict_cnt;

   modport master (
      output enable, req_p1, req_p2, addr_p1, addr_p2, rom_q,
      input  gnt_p1, gnt_p2, rvalid_p1, rvalid_p2, rdata, rom_address, conflict_cnt
   );

   modport slave (
      input  enable, req_p1, req_p2, addr_p1, addr_p2, rom_q,
      output gnt_p1, gnt_p2, rvalid_p1, rvalid_p2, rdata, rom_address, conflict_cnt
   );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port between
// player 1 and player 2. Grants are combinational, the ROM address is
// registered, and a tag pipeline of ROM_LAT stages routes each returned
// palette index back to the player that issued the read.
module sprite_rom_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 4,
   parameter int ROM_LAT = 1    // 1..3; 1 = negedge ROM, 2 = posedge-registered ROM
) (
   input  logic                  vga_clk,
   input  logic                  reset,
   sprite_rom_arbiter_if.slave   bus
);
   localparam logic P1 = 1'b0;
   localparam logic P2 = 1'b1;

   logic               r_last_win;
   logic [ROM_LAT-1:0] r_vld_pipe;
   logic [ROM_LAT-1:0] r_id_pipe;
   logic [ADDR_W-1:0]  r_rom_address;
   logic [DATA_W-1:0]  r_rdata;
   logic               r_rvalid_p1;
   logic               r_rvalid_p2;
   logic [7:0]         r_conflict_cnt;

   logic               w_gnt_p1;
   logic               w_gnt_p2;
   logic               w_any_gnt;
   logic               w_win_id;
   logic               w_tie;

   // Arbitration: lone requester always wins, a tie goes to whoever did not win last.
   always_comb begin
      w_gnt_p1 = 1'b0;
      w_gnt_p2 = 1'b0;
      w_tie    = bus.enable & bus.req_p1 & bus.req_p2;
      if (bus.enable) begin
         if (bus.req_p1 && bus.req_p2) begin
            w_gnt_p1 = (r_last_win == P2);
            w_gnt_p2 = (r_last_win == P1);
         end else begin
            w_gnt_p1 = bus.req_p1;
            w_gnt_p2 = bus.req_p2;
         end
      end
      w_any_gnt = w_gnt_p1 | w_gnt_p2;
      w_win_id  = w_gnt_p2 ? P2 : P1;
   end

   // Issue: latch the winner's address and remember who won for the next tie.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_rom_address <= '0;
         r_last_win    <= P2;
      end else if (w_any_gnt) begin
         r_rom_address <= w_gnt_p1 ? bus.addr_p1 : bus.addr_p2;
         r_last_win    <= w_win_id;
      end
   end

   // Tag pipeline: one stage per cycle of ROM latency, stage 0 fed by the issue edge.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_vld_pipe <= '0;
         r_id_pipe  <= '0;
      end else begin
         for (int i = ROM_LAT - 1; i > 0; i--) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_id_pipe[i]  <= r_id_pipe[i-1];
         end
         r_vld_pipe[0] <= w_any_gnt;
         r_id_pipe[0]  <= w_win_id;
      end
   end

   // Return: capture ROM data when the oldest tag is valid and pulse that player's rvalid.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_rdata     <= '0;
         r_rvalid_p1 <= 1'b0;
         r_rvalid_p2 <= 1'b0;
      end else begin
         r_rvalid_p1 <= r_vld_pipe[ROM_LAT-1] & (r_id_pipe[ROM_LAT-1] == P1);
         r_rvalid_p2 <= r_vld_pipe[ROM_LAT-1] & (r_id_pipe[ROM_LAT-1] == P2);
         if (r_vld_pipe[ROM_LAT-1])
            r_rdata <= bus.rom_q;
      end
   end

   // Conflict counter: cycles where both players asked while enabled, saturating at 255.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset)
         r_conflict_cnt <= '0;
      else if (w_tie && r_conflict_cnt != 8'hFF)
         r_conflict_cnt <= r_conflict_cnt + 8'd1;
   end

   assign bus.gnt_p1       = w_gnt_p1;
   assign bus.gnt_p2       = w_gnt_p2;
   assign bus.rom_address  = r_rom_address;
   assign bus.rdata        = r_rdata;
   assign bus.rvalid_p1    = r_rvalid_p1;
   assign bus.rvalid_p2    = r_rvalid_p2;
   assign bus.conflict_cnt = r_conflict_cnt;
endmodule
